// File: rtl/sb_tx_msg_arbiter_pkg.sv
// sb_tx_msg_arbiter_pkg: sideband TX message widths, message codes and arbiter FSM states
package sb_tx_msg_arbiter_pkg;
  localparam int SB_MSG_WIDTH = 4;
  localparam int SB_DATA_WIDTH = 16;
  localparam logic [SB_MSG_WIDTH-1:0] SB_MSG_NOP = 4'h0;
  localparam logic [SB_MSG_WIDTH-1:0] SB_MSG_PT_REQ = 4'h5;
  localparam logic [SB_MSG_WIDTH-1:0] SB_MSG_PT_RESP = 4'hA;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE, ST_DONE} arb_state_e;
endpackage

// File: rtl/sb_tx_msg_arbiter_if.sv
// sb_tx_msg_arbiter_if: requester and SB TX signals shared by the arbiter and its environment
interface sb_tx_msg_arbiter_if import sb_tx_msg_arbiter_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int MSG_W = SB_MSG_WIDTH,
  parameter int DATA_W = SB_DATA_WIDTH
);
  logic [N_REQ-1:0] i_req_valid;
  logic [N_REQ*MSG_W-1:0] i_req_msg;
  logic [N_REQ*DATA_W-1:0] i_req_data;
  logic [N_REQ-1:0] i_req_data_valid;
  logic i_sb_busy;
  logic o_tx_msg_valid;
  logic [MSG_W-1:0] o_encoded_SB_msg;
  logic [DATA_W-1:0] o_tx_data_bus;
  logic o_tx_data_valid;
  logic [N_REQ-1:0] o_grant;
  logic [N_REQ-1:0] o_req_done;
  logic o_timeout;
  modport master (
    output i_req_valid, i_req_msg, i_req_data, i_req_data_valid, i_sb_busy,
    input o_tx_msg_valid, o_encoded_SB_msg, o_tx_data_bus, o_tx_data_valid, o_grant, o_req_done, o_timeout
  );
  modport slave (
    input i_req_valid, i_req_msg, i_req_data, i_req_data_valid, i_sb_busy,
    output o_tx_msg_valid, o_encoded_SB_msg, o_tx_data_bus, o_tx_data_valid, o_grant, o_req_done, o_timeout
  );
endinterface

// File: rtl/sb_tx_msg_arbiter_rr_priority_picker.sv
// sb_tx_msg_arbiter_rr_priority_picker: first set request at or above ptr, wrapping modulo N_REQ
module sb_tx_msg_arbiter_rr_priority_picker #(
  parameter int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W:0] s;
  // scan from farthest to nearest so the candidate closest to ptr is written last
  always_comb begin
    grant = '0;
    idx = '0;
    s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IDX_W+1)'(i);
      s = s >= (IDX_W+1)'(N_REQ) ? s - (IDX_W+1)'(N_REQ) : s;
      if (req[s[IDX_W-1:0]]) begin
        grant = '0;
        grant[s[IDX_W-1:0]] = 1'b1;
        idx = s[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/sb_tx_msg_arbiter.sv
// sb_tx_msg_arbiter: round-robin sharing of the sideband TX message port between requesters
module sb_tx_msg_arbiter import sb_tx_msg_arbiter_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int MSG_W = SB_MSG_WIDTH,
  parameter int DATA_W = SB_DATA_WIDTH,
  parameter int TIMEOUT_CYC = 255,
  localparam int IDX_W = $clog2(N_REQ),
  localparam int CNT_W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input logic i_clk,
  input logic i_rst,
  sb_tx_msg_arbiter_if.slave bus
);
  arb_state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d, pick_idx, ptr_nxt;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, pick_grant;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic dv_q, dv_d, valid_q, valid_d, timeout_q, timeout_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [MSG_W-1:0] msg_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];
  for (genvar k = 0; k < N_REQ; k++) begin : g_slice
    assign msg_arr[k] = bus.i_req_msg[k*MSG_W +: MSG_W];
    assign data_arr[k] = bus.i_req_data[k*DATA_W +: DATA_W];
  end
  sb_tx_msg_arbiter_rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
    .req(bus.i_req_valid), .ptr(ptr_q), .grant(pick_grant), .idx(pick_idx)
  );
  assign ptr_nxt = owner_q == IDX_W'(N_REQ - 1) ? '0 : owner_q + 1'b1;
  assign cnt_nxt = cnt_q + 1'b1;
  // next-state logic: arbitrate in IDLE, hold the latched message until the SB busy cycle completes
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    msg_d = msg_q;
    data_d = data_q;
    dv_d = dv_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    done_d = '0;
    timeout_d = 1'b0;
    busy_d = bus.i_sb_busy;
    case (state_q)
      ST_IDLE: if (|bus.i_req_valid && !bus.i_sb_busy) begin
        state_d = ST_ISSUE;
        owner_d = pick_idx;
        grant_d = pick_grant;
        msg_d = msg_arr[pick_idx];
        dv_d = bus.i_req_data_valid[pick_idx];
        data_d = bus.i_req_data_valid[pick_idx] ? data_arr[pick_idx] : '0;
        valid_d = 1'b1;
        cnt_d = '0;
      end
      ST_ISSUE: if (bus.i_sb_busy) begin
        state_d = ST_WAIT_DONE;
        valid_d = 1'b0;
      end else if (TIMEOUT_CYC != 0 && cnt_nxt == CNT_W'(TIMEOUT_CYC)) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        timeout_d = 1'b1;
        ptr_d = ptr_nxt;
        grant_d = '0;
        msg_d = '0;
        data_d = '0;
        dv_d = 1'b0;
      end else begin
        cnt_d = cnt_nxt;
      end
      ST_WAIT_DONE: if (busy_q && !bus.i_sb_busy) begin
        state_d = ST_DONE;
        done_d = grant_q;
        grant_d = '0;
        msg_d = '0;
        data_d = '0;
        dv_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d = ptr_nxt;
      end
    endcase
  end
  // state and registered outputs; reset aborts any transfer without a pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      grant_q <= '0;
      msg_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      done_q <= '0;
      timeout_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      msg_q <= msg_d;
      data_q <= data_d;
      dv_q <= dv_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      busy_q <= busy_d;
    end
  end
  assign bus.o_tx_msg_valid = valid_q;
  assign bus.o_encoded_SB_msg = msg_q;
  assign bus.o_tx_data_bus = data_q;
  assign bus.o_tx_data_valid = dv_q;
  assign bus.o_grant = grant_q;
  assign bus.o_req_done = done_q;
  assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// tb_sb_tx_msg_arbiter: directed checks of grant order, hold, done, timeout and reset behaviour
module tb_sb_tx_msg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  sb_tx_msg_arbiter_if #(.N_REQ(2), .MSG_W(4), .DATA_W(16)) bus ();
  sb_tx_msg_arbiter #(.N_REQ(2), .MSG_W(4), .DATA_W(16), .TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] m, input logic [15:0] d, input logic dv);
    bus.i_req_msg[k*4 +: 4] = m;
    bus.i_req_data[k*16 +: 16] = d;
    bus.i_req_data_valid[k] = dv;
    bus.i_req_valid[k] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_sb_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // one transfer: busy rises 2 cycles after valid, lasts 4 cycles; mid_drop/drop masks release requesters
  task automatic serve(input int idx, input logic [3:0] em, input logic [15:0] ed, input logic edv,
                       input logic [1:0] mid_drop, input logic [1:0] drop);
    logic [31:0] g;
    g = 32'd1 << idx;
    tick();
    chk("grant", 32'(bus.o_grant), g);
    chk("valid_rise", 32'(bus.o_tx_msg_valid), 1);
    chk("msg", 32'(bus.o_encoded_SB_msg), 32'(em));
    chk("data", 32'(bus.o_tx_data_bus), 32'(ed));
    chk("data_valid", 32'(bus.o_tx_data_valid), 32'(edv));
    for (int k = 0; k < 2; k++)
      if (mid_drop[k]) begin
        bus.i_req_valid[k] = 1'b0;
        bus.i_req_msg[k*4 +: 4] = 4'hA;
      end
    tick();
    chk("msg_hold", 32'(bus.o_encoded_SB_msg), 32'(em));
    tick();
    chk("valid_hold", 32'(bus.o_tx_msg_valid), 1);
    bus.i_sb_busy = 1'b1;
    tick();
    chk("valid_drop", 32'(bus.o_tx_msg_valid), 0);
    chk("grant_hold", 32'(bus.o_grant), g);
    chk("no_early_done", 32'(bus.o_req_done), 0);
    tick();
    tick();
    tick();
    bus.i_sb_busy = 1'b0;
    tick();
    chk("done", 32'(bus.o_req_done), g);
    chk("grant_clr", 32'(bus.o_grant), 0);
    bus.i_req_valid = bus.i_req_valid & ~drop;
    tick();
    chk("done_one_cycle", 32'(bus.o_req_done), 0);
  endtask

  initial begin
    int vcnt;
    logic done_seen;
    bus.i_req_msg = '0;
    bus.i_req_data = '0;
    bus.i_req_data_valid = '0;
    do_reset();
    chk("rst_valid", 32'(bus.o_tx_msg_valid), 0);
    chk("rst_grant", 32'(bus.o_grant), 0);
    chk("rst_msg", 32'(bus.o_encoded_SB_msg), 0);
    chk("rst_done", 32'(bus.o_req_done), 0);
    chk("rst_timeout", 32'(bus.o_timeout), 0);
    // single request
    set_req(0, 4'h5, 16'h0013, 1'b1);
    serve(0, 4'h5, 16'h0013, 1'b1, 2'b00, 2'b01);
    tick();
    chk("idle_grant", 32'(bus.o_grant), 0);
    chk("idle_valid", 32'(bus.o_tx_msg_valid), 0);
    // simultaneous requests held: 0,1,0,1; req1 has no data field so its bus reads 0
    do_reset();
    set_req(0, 4'h7, 16'h1234, 1'b1);
    set_req(1, 4'h3, 16'hBEEF, 1'b0);
    serve(0, 4'h7, 16'h1234, 1'b1, 2'b00, 2'b00);
    serve(1, 4'h3, 16'h0000, 1'b0, 2'b00, 2'b00);
    serve(0, 4'h7, 16'h1234, 1'b1, 2'b00, 2'b00);
    serve(1, 4'h3, 16'h0000, 1'b0, 2'b00, 2'b11);
    // busy already high
    do_reset();
    bus.i_sb_busy = 1'b1;
    set_req(1, 4'h9, 16'h00C1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_block_grant", 32'(bus.o_grant), 0);
      chk("busy_block_valid", 32'(bus.o_tx_msg_valid), 0);
    end
    bus.i_sb_busy = 1'b0;
    serve(1, 4'h9, 16'h00C1, 1'b1, 2'b00, 2'b10);
    // requester drops and changes msg mid-transfer
    do_reset();
    set_req(0, 4'h5, 16'h0013, 1'b1);
    serve(0, 4'h5, 16'h0013, 1'b1, 2'b01, 2'b00);
    // timeout with busy never asserted
    do_reset();
    set_req(0, 4'h2, 16'h0002, 1'b1);
    set_req(1, 4'h4, 16'h0004, 1'b1);
    tick();
    chk("to_grant", 32'(bus.o_grant), 32'b01);
    vcnt = 1;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      done_seen = done_seen | (|bus.o_req_done);
      if (!bus.o_tx_msg_valid) break;
      vcnt++;
    end
    chk("to_valid_cycles", 32'(vcnt), 8);
    chk("to_pulse", 32'(bus.o_timeout), 1);
    chk("to_no_done", 32'(done_seen), 0);
    chk("to_grant_clr", 32'(bus.o_grant), 0);
    bus.i_req_valid[0] = 1'b0;
    tick();
    chk("to_pulse_end", 32'(bus.o_timeout), 0);
    chk("to_next_grant", 32'(bus.o_grant), 32'b10);
    // reset during WAIT_DONE
    do_reset();
    set_req(0, 4'h6, 16'h0066, 1'b1);
    set_req(1, 4'h8, 16'h0088, 1'b1);
    tick();
    tick();
    tick();
    bus.i_sb_busy = 1'b1;
    tick();
    chk("mr_wait_grant", 32'(bus.o_grant), 32'b01);
    rst = 1'b1;
    bus.i_sb_busy = 1'b0;
    tick();
    chk("mr_grant", 32'(bus.o_grant), 0);
    chk("mr_valid", 32'(bus.o_tx_msg_valid), 0);
    chk("mr_msg", 32'(bus.o_encoded_SB_msg), 0);
    chk("mr_done", 32'(bus.o_req_done), 0);
    rst = 1'b0;
    tick();
    chk("mr_no_done", 32'(bus.o_req_done), 0);
    chk("mr_prio", 32'(bus.o_grant), 32'b01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
